// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with per-register rename status
// (ROB tag of the pending producer) and a circular bank of status-table
// checkpoints for one-cycle branch recovery.
// Optional feature macro: RENAME_CKPT_EN enables the checkpoint bank. Without
// it there is no snapshot storage, ck_restore clears all rename status like a
// flush, ck_take/ck_release are ignored and ck_full/ck_count/ck_id read 0.
// Handshakes: iss_valid, cm_valid, ck_take, ck_restore, ck_release and flush
// are single-cycle strobes with no back-pressure; the caller must not assert
// ck_take while ck_full is high (it is ignored if it does).
module rename_reg_file #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int TAG_W      = 4,
    parameter int CKPT_DEPTH = 4,
    localparam int RID_W     = $clog2(NREG),
    localparam int CK_W      = $clog2(CKPT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [RID_W-1:0] iss_rs,
    input  logic [RID_W-1:0] iss_rt,
    input  logic [RID_W-1:0] iss_rd,
    input  logic [TAG_W-1:0] iss_tag,
    output logic [XLEN-1:0]  vj,
    output logic [XLEN-1:0]  vk,
    output logic [TAG_W-1:0] qj,
    output logic [TAG_W-1:0] qk,
    input  logic             cm_valid,
    input  logic [RID_W-1:0] cm_rd,
    input  logic [TAG_W-1:0] cm_tag,
    input  logic [XLEN-1:0]  cm_value,
    input  logic             ck_take,
    output logic [CK_W-1:0]  ck_id,
    output logic             ck_full,
    output logic [CK_W:0]    ck_count,
    input  logic             ck_restore,
    input  logic [CK_W-1:0]  ck_restore_id,
    input  logic             ck_release,
    input  logic             flush
);

    logic [XLEN-1:0]  values     [NREG];
    logic [TAG_W-1:0] status     [NREG];
    logic [TAG_W-1:0] status_nx  [NREG];
    logic [TAG_W-1:0] restore_st [NREG];
    logic             issue_en;
    logic             cm_en;

    assign issue_en = iss_valid && (iss_rd != '0) && !ck_restore && !flush;
    assign cm_en    = cm_valid && (cm_rd != '0);

    // Source j read: zero register, commit bypass, else stored tag/value
    always_comb begin
        qj = '0;
        vj = '0;
        if (iss_rs != '0) begin
            if (cm_valid && (cm_rd == iss_rs) && (status[iss_rs] == cm_tag)) begin
                vj = cm_value;
            end else begin
                qj = status[iss_rs];
                if (status[iss_rs] == '0) vj = values[iss_rs];
            end
        end
    end

    // Source k read: same priority as source j
    always_comb begin
        qk = '0;
        vk = '0;
        if (iss_rt != '0) begin
            if (cm_valid && (cm_rd == iss_rt) && (status[iss_rt] == cm_tag)) begin
                vk = cm_value;
            end else begin
                qk = status[iss_rt];
                if (status[iss_rt] == '0) vk = values[iss_rt];
            end
        end
    end

    // Status table after this cycle's issue and commit (issue beats commit clear)
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            status_nx[i] = status[i];
            if (issue_en && (iss_rd == RID_W'(i))) begin
                status_nx[i] = iss_tag;
            end else if (cm_en && (cm_rd == RID_W'(i)) && (status[i] == cm_tag)) begin
                status_nx[i] = '0;
            end
        end
    end

`ifdef RENAME_CKPT_EN
    logic [TAG_W-1:0] snap [CKPT_DEPTH][NREG];
    logic [CK_W-1:0]  head;
    logic [CK_W-1:0]  tail;
    logic [CK_W:0]    count;
    logic [CK_W-1:0]  head_rs;
    logic [CK_W-1:0]  restore_count;
    logic             take_en;
    logic             release_en;

    assign ck_full    = (count == (CK_W+1)'(CKPT_DEPTH));
    assign ck_count   = count;
    assign ck_id      = tail;
    assign take_en    = ck_take && iss_valid && !ck_full && !ck_restore && !flush;
    assign release_en = ck_release && (count != '0);
    // A release alongside a restore only counts when it does not free the restored slot
    assign head_rs       = (release_en && (ck_restore_id != head)) ? head + 1'b1 : head;
    assign restore_count = ck_restore_id - head_rs;

    // Restored status: selected snapshot with this cycle's commit clear applied
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            restore_st[i] = snap[ck_restore_id][i];
            if (cm_en && (cm_rd == RID_W'(i)) && (snap[ck_restore_id][i] == cm_tag)) begin
                restore_st[i] = '0;
            end
        end
    end

    // Snapshot storage: commit clears matching tags, take captures the next status
    always_ff @(posedge clk) begin
        for (int c = 0; c < CKPT_DEPTH; c++) begin
            for (int i = 0; i < NREG; i++) begin
                if (cm_en && (cm_rd == RID_W'(i)) && (snap[c][i] == cm_tag)) begin
                    snap[c][i] <= '0;
                end
            end
        end
        if (take_en) begin
            for (int i = 0; i < NREG; i++) begin
                snap[tail][i] <= status_nx[i];
            end
        end
    end

    // Checkpoint ring pointers and live-slot count
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (ck_restore) begin
            head  <= head_rs;
            tail  <= ck_restore_id;
            count <= {1'b0, restore_count};
        end else begin
            if (take_en)    tail <= tail + 1'b1;
            if (release_en) head <= head + 1'b1;
            case ({take_en, release_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic ckpt_unused;

    assign ck_full     = 1'b0;
    assign ck_count    = '0;
    assign ck_id       = '0;
    assign ckpt_unused = ^{ck_take, ck_release, ck_restore_id};

    // Without a bank, a restore simply empties the status table
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            restore_st[i] = '0;
        end
    end
`endif

    // Register values and live status table
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                values[i] <= '0;
                status[i] <= '0;
            end
        end else begin
            if (cm_en) values[cm_rd] <= cm_value;
            for (int i = 0; i < NREG; i++) begin
                if (flush)           status[i] <= '0;
                else if (ck_restore) status[i] <= restore_st[i];
                else                 status[i] <= status_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed scenarios for rename_reg_file. Expected values
// are pushed into exp_q while stimulus is driven and popped when the outputs
// are sampled. Checkpoint scenarios follow the RENAME_CKPT_EN build setting.
module tb_rename_reg_file;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int TAG_W      = 4;
    localparam int CKPT_DEPTH = 4;
    localparam int RID_W      = $clog2(NREG);
    localparam int CK_W       = $clog2(CKPT_DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             iss_valid;
    logic [RID_W-1:0] iss_rs, iss_rt, iss_rd;
    logic [TAG_W-1:0] iss_tag;
    logic [XLEN-1:0]  vj, vk;
    logic [TAG_W-1:0] qj, qk;
    logic             cm_valid;
    logic [RID_W-1:0] cm_rd;
    logic [TAG_W-1:0] cm_tag;
    logic [XLEN-1:0]  cm_value;
    logic             ck_take;
    logic [CK_W-1:0]  ck_id;
    logic             ck_full;
    logic [CK_W:0]    ck_count;
    logic             ck_restore;
    logic [CK_W-1:0]  ck_restore_id;
    logic             ck_release;
    logic             flush;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n_run  = 0;
    int          n_fail = 0;

    rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .CKPT_DEPTH(CKPT_DEPTH)) dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_rd(iss_rd), .iss_tag(iss_tag), .vj(vj), .vk(vk), .qj(qj), .qk(qk),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_value(cm_value),
        .ck_take(ck_take), .ck_id(ck_id), .ck_full(ck_full), .ck_count(ck_count),
        .ck_restore(ck_restore), .ck_restore_id(ck_restore_id), .ck_release(ck_release),
        .flush(flush)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic idle();
        iss_valid = 0; iss_rs = '0; iss_rt = '0; iss_rd = '0; iss_tag = '0;
        cm_valid = 0; cm_rd = '0; cm_tag = '0; cm_value = '0;
        ck_take = 0; ck_restore = 0; ck_restore_id = '0; ck_release = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        repeat (2) tick();
        rst = 0;
        iss_rs = 5; iss_rt = 31;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL reset_qj got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL reset_vj got=%0h exp=%0h", vj, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(qk) !== e) begin n_fail++; $display("FAIL reset_qk got=%0h exp=%0h", qk, e); end
        e = exp_q.pop_front(); n_run++;
        if (vk !== e) begin n_fail++; $display("FAIL reset_vk got=%0h exp=%0h", vk, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_full) !== e) begin n_fail++; $display("FAIL reset_full got=%0h exp=%0h", ck_full, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL reset_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL reset_id got=%0h exp=%0h", ck_id, e); end
        tick();
    endtask

    task automatic test_issue_commit();
        idle(); iss_valid = 1; iss_rd = 5; iss_tag = 3; iss_rs = 5;
        exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL issue_reads_old got=%0h exp=%0h", qj, e); end
        tick();
        idle(); iss_rs = 5;
        exp_q.push_back(3); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL pending_qj got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL pending_vj got=%0h exp=%0h", vj, e); end
        tick();
        idle(); iss_rs = 5; cm_valid = 1; cm_rd = 5; cm_tag = 3; cm_value = 32'hAB;
        exp_q.push_back(0); exp_q.push_back(32'hAB);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL bypass_qj got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL bypass_vj got=%0h exp=%0h", vj, e); end
        tick();
        idle(); iss_rt = 5;
        exp_q.push_back(0); exp_q.push_back(32'hAB);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qk) !== e) begin n_fail++; $display("FAIL committed_qk got=%0h exp=%0h", qk, e); end
        e = exp_q.pop_front(); n_run++;
        if (vk !== e) begin n_fail++; $display("FAIL committed_vk got=%0h exp=%0h", vk, e); end
        tick();
    endtask

    task automatic test_same_rd();
        idle(); iss_valid = 1; iss_rd = 7; iss_tag = 1;
        tick();
        idle(); iss_valid = 1; iss_rd = 7; iss_rs = 7; iss_tag = 2;
        exp_q.push_back(1);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL rd_eq_rs_old got=%0h exp=%0h", qj, e); end
        tick();
        idle(); iss_rs = 7; cm_valid = 1; cm_rd = 7; cm_tag = 1; cm_value = 9;
        exp_q.push_back(2); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL stale_commit_qj got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL stale_commit_vj got=%0h exp=%0h", vj, e); end
        tick();
        idle(); iss_rs = 7;
        exp_q.push_back(2);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL stale_commit_kept got=%0h exp=%0h", qj, e); end
        tick();
        idle(); iss_valid = 1; iss_rd = 9; iss_tag = 4;
        tick();
        idle(); iss_valid = 1; iss_rd = 9; iss_tag = 5; iss_rs = 9;
        cm_valid = 1; cm_rd = 9; cm_tag = 4; cm_value = 32'h55;
        exp_q.push_back(0); exp_q.push_back(32'h55);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL issue_commit_qj got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL issue_commit_vj got=%0h exp=%0h", vj, e); end
        tick();
        idle(); iss_rs = 9;
        exp_q.push_back(5);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL issue_wins got=%0h exp=%0h", qj, e); end
        tick();
    endtask

`ifdef RENAME_CKPT_EN
    task automatic test_ckpt_restore();
        idle(); iss_valid = 1; iss_rd = 4; iss_tag = 1;
        tick();
        idle(); iss_valid = 1; ck_take = 1; iss_rd = 11; iss_tag = 2;
        exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL take_id got=%0h exp=%0h", ck_id, e); end
        tick();
        idle(); iss_valid = 1; iss_rd = 4; iss_tag = 6;
        exp_q.push_back(1); exp_q.push_back(1);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL take_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL take_tail got=%0h exp=%0h", ck_id, e); end
        tick();
        idle(); iss_rs = 4;
        exp_q.push_back(6);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL spec_issue got=%0h exp=%0h", qj, e); end
        ck_restore = 1; ck_restore_id = 0; iss_valid = 1; iss_rd = 4; iss_tag = 7; ck_take = 1;
        tick();
        idle(); iss_rs = 4; iss_rt = 11;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL restore_r4 got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(qk) !== e) begin n_fail++; $display("FAIL restore_take_issue got=%0h exp=%0h", qk, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL restore_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL restore_id got=%0h exp=%0h", ck_id, e); end
        tick();
    endtask

    task automatic test_commit_vs_snapshot();
        idle(); iss_valid = 1; ck_take = 1; iss_rd = 3; iss_tag = 5;
        tick();
        idle(); iss_valid = 1; iss_rd = 3; iss_tag = 9;
        tick();
        idle(); iss_rs = 3; cm_valid = 1; cm_rd = 3; cm_tag = 5; cm_value = 32'h33;
        exp_q.push_back(9);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL young_tag got=%0h exp=%0h", qj, e); end
        tick();
        idle(); ck_restore = 1; ck_restore_id = 0; cm_valid = 1; cm_rd = 11; cm_tag = 2; cm_value = 32'h11;
        tick();
        idle(); iss_rs = 3; iss_rt = 11;
        exp_q.push_back(0); exp_q.push_back(32'h33); exp_q.push_back(0); exp_q.push_back(32'h11);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL no_resurrect_q got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL no_resurrect_v got=%0h exp=%0h", vj, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(qk) !== e) begin n_fail++; $display("FAIL restore_cycle_commit_q got=%0h exp=%0h", qk, e); end
        e = exp_q.pop_front(); n_run++;
        if (vk !== e) begin n_fail++; $display("FAIL restore_cycle_commit_v got=%0h exp=%0h", vk, e); end
        tick();
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            idle(); iss_valid = 1; ck_take = 1; iss_rd = RID_W'(20 + i); iss_tag = TAG_W'(i + 1);
            exp_q.push_back(32'(i));
            #2;
            e = exp_q.pop_front(); n_run++;
            if (32'(ck_id) !== e) begin n_fail++; $display("FAIL fill_id got=%0h exp=%0h", ck_id, e); end
            tick();
        end
        idle(); iss_valid = 1; ck_take = 1; iss_rd = 24; iss_tag = 5;
        exp_q.push_back(1); exp_q.push_back(4);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_full) !== e) begin n_fail++; $display("FAIL full_flag got=%0h exp=%0h", ck_full, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL full_count got=%0h exp=%0h", ck_count, e); end
        tick();
        idle(); ck_release = 1;
        exp_q.push_back(4);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL take_when_full got=%0h exp=%0h", ck_count, e); end
        tick();
        idle(); ck_restore = 1; ck_restore_id = 2;
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL release_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL wrap_id got=%0h exp=%0h", ck_id, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_full) !== e) begin n_fail++; $display("FAIL release_full got=%0h exp=%0h", ck_full, e); end
        tick();
        idle(); iss_rs = 22; iss_rt = 23;
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL slot2_r22 got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(qk) !== e) begin n_fail++; $display("FAIL slot2_r23 got=%0h exp=%0h", qk, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL head1_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL head1_id got=%0h exp=%0h", ck_id, e); end
        ck_restore = 1; ck_restore_id = 1; ck_release = 1;
        tick();
        idle();
        exp_q.push_back(0); exp_q.push_back(1);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL restore_head_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL restore_head_id got=%0h exp=%0h", ck_id, e); end
        tick();
    endtask
`else
    task automatic test_restore_as_flush();
        idle(); iss_valid = 1; iss_rd = 6; iss_tag = 3; ck_take = 1;
        tick();
        idle(); iss_rs = 6;
        exp_q.push_back(3); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL nock_issue got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL nock_take_count got=%0h exp=%0h", ck_count, e); end
        ck_restore = 1; ck_restore_id = 2; ck_release = 1;
        cm_valid = 1; cm_rd = 14; cm_tag = 2; cm_value = 32'h44;
        tick();
        idle(); iss_rs = 6; iss_rt = 14;
        exp_q.push_back(0); exp_q.push_back(32'h44); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL nock_restore_clear got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vk !== e) begin n_fail++; $display("FAIL nock_restore_commit got=%0h exp=%0h", vk, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL nock_id got=%0h exp=%0h", ck_id, e); end
        tick();
    endtask
`endif

    task automatic test_flush();
        logic [XLEN-1:0] rv;
        rv = XLEN'($urandom_range(1, 32'hFFFF));
`ifdef RENAME_CKPT_EN
        for (int i = 0; i < 3; i++) begin
            idle(); iss_valid = 1; ck_take = 1; iss_rd = 25; iss_tag = 6;
            tick();
        end
        exp_q.push_back(3);
`else
        exp_q.push_back(0);
`endif
        idle(); iss_rs = 7;
        exp_q.push_back(2);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL preflush_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL preflush_r7 got=%0h exp=%0h", qj, e); end
        flush = 1; cm_valid = 1; cm_rd = 13; cm_tag = 1; cm_value = rv;
        iss_valid = 1; iss_rd = 26; iss_tag = 3; ck_take = 1;
        tick();
        idle(); iss_rs = 7; iss_rt = 5;
        exp_q.push_back(0); exp_q.push_back(9); exp_q.push_back(32'hAB);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(qj) !== e) begin n_fail++; $display("FAIL flush_r7_q got=%0h exp=%0h", qj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL flush_r7_value got=%0h exp=%0h", vj, e); end
        e = exp_q.pop_front(); n_run++;
        if (vk !== e) begin n_fail++; $display("FAIL flush_r5_value got=%0h exp=%0h", vk, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL flush_count got=%0h exp=%0h", ck_count, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_id) !== e) begin n_fail++; $display("FAIL flush_id got=%0h exp=%0h", ck_id, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_full) !== e) begin n_fail++; $display("FAIL flush_full got=%0h exp=%0h", ck_full, e); end
        tick();
        idle(); iss_rs = 13; iss_rt = 26; ck_release = 1;
        exp_q.push_back(rv); exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (vj !== e) begin n_fail++; $display("FAIL flush_commit_value got=%0h exp=%0h", vj, e); end
        e = exp_q.pop_front(); n_run++;
        if (32'(qk) !== e) begin n_fail++; $display("FAIL flush_issue_ignored got=%0h exp=%0h", qk, e); end
        tick();
        idle();
        exp_q.push_back(0);
        #2;
        e = exp_q.pop_front(); n_run++;
        if (32'(ck_count) !== e) begin n_fail++; $display("FAIL empty_release got=%0h exp=%0h", ck_count, e); end
        tick();
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_issue_commit();
        test_same_rd();
`ifdef RENAME_CKPT_EN
        test_ckpt_restore();
        test_commit_vs_snapshot();
        test_fill_wrap();
        test_flush();
`else
        test_flush();
        test_restore_as_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
